// File: rtl/rgb_pin_decoder.sv
// Pin-side RGB monitor: synchronizes the active-low pads, debounces the decoded
// color and reports each accepted change with the dwell time of the color it replaced.
module rgb_pin_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int DUR_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rgb_r_n,
    input  logic                 rgb_g_n,
    input  logic                 rgb_b_n,
    output logic                 color_valid,
    output logic [2:0]           color_code,
    output logic [DUR_WIDTH-1:0] duration,
    output logic [15:0]          event_count
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

    logic [2:0]           sync1_q, sync1_d;
    logic [2:0]           sync2_q, sync2_d;
    logic [2:0]           cand_q, cand_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           cur_q, cur_d;
    logic                 valid_q, valid_d;
    logic [2:0]           code_q, code_d;
    logic [DUR_WIDTH-1:0] dur_q, dur_d;
    logic [DUR_WIDTH-1:0] dwell_q, dwell_d;
    logic [15:0]          evt_q, evt_d;
    logic [2:0]           s;
    logic                 accept;

    assign s = ~sync2_q;

    always_comb begin
        sync1_d = {rgb_r_n, rgb_g_n, rgb_b_n};
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        valid_d = 1'b0;
        code_d  = code_q;
        dur_d   = dur_q;
        dwell_d = dwell_q;
        evt_d   = evt_q;
        accept  = 1'b0;

        // A differing sample restarts the filter; an accept fires on the edge the
        // counter reaches its ceiling (or sits there) with a candidate that is new.
        if (s != cand_q) begin
            cand_d = s;
            cnt_d  = '0;
        end else begin
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if ((cnt_q >= CNT_ACC) && (cand_q != cur_q)) begin
                accept = 1'b1;
            end
        end

        if (accept) begin
            cur_d   = cand_q;
            code_d  = cand_q;
            valid_d = 1'b1;
            dur_d   = dwell_q;
            dwell_d = DUR_WIDTH'(1);
            evt_d   = evt_q + 16'd1;
        end else if (dwell_q != '1) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            cand_q  <= 3'b000;
            cnt_q   <= '0;
            cur_q   <= 3'b000;
            valid_q <= 1'b0;
            code_q  <= 3'b000;
            dur_q   <= '0;
            dwell_q <= '0;
            evt_q   <= 16'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            dur_q   <= dur_d;
            dwell_q <= dwell_d;
            evt_q   <= evt_d;
        end
    end

    assign color_valid = valid_q;
    assign color_code  = code_q;
    assign duration    = dur_q;
    assign event_count = evt_q;

endmodule

// File: tb/tb_rgb_pin_decoder.sv
// Scoreboard bench for rgb_pin_decoder: two instances (32-bit and 8-bit duration)
// share the pins; expected events are queued at stimulus time and popped on color_valid.
module tb_rgb_pin_decoder;

    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rgb_r_n = 1'b1, rgb_g_n = 1'b1, rgb_b_n = 1'b1;
    logic        v32, v8;
    logic [2:0]  code32, code8;
    logic [31:0] dur32;
    logic [7:0]  dur8;
    logic [15:0] cnt32, cnt8;

    rgb_pin_decoder #(.STABLE_CYCLES(STABLE), .DUR_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .rgb_r_n(rgb_r_n), .rgb_g_n(rgb_g_n), .rgb_b_n(rgb_b_n),
        .color_valid(v32), .color_code(code32), .duration(dur32), .event_count(cnt32)
    );

    rgb_pin_decoder #(.STABLE_CYCLES(STABLE), .DUR_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .rgb_r_n(rgb_r_n), .rgb_g_n(rgb_g_n), .rgb_b_n(rgb_b_n),
        .color_valid(v8), .color_code(code8), .duration(dur8), .event_count(cnt8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [2:0]  code;
        logic [31:0] dur;
        bit          dur_dc;
        logic [15:0] cnt;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    int checks = 0;
    int failures = 0;
    int last_c = 0;
    bit first_after_rst = 1'b1;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_evt(input int at_cyc, input logic [2:0] col);
        exp_t e;
        exp_cnt++;
        e.at     = at_cyc + LAT;
        e.code   = col;
        e.dur    = 32'(at_cyc - last_c);
        e.dur_dc = first_after_rst;
        e.cnt    = exp_cnt;
        q32.push_back(e);
        if (e.dur > 32'd255) e.dur = 32'd255;
        q8.push_back(e);
        first_after_rst = 1'b0;
        last_c = at_cyc;
    endtask

    // Drive the pins with an active-high color at the current negedge.
    task automatic change(input logic [2:0] col, input bit expect_evt);
        {rgb_r_n, rgb_g_n, rgb_b_n} = ~col;
        if (expect_evt) push_evt(cyc, col);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid32"}, v32, 0);
        chk({tag, "_code32"}, code32, 0);
        chk({tag, "_dur32"}, dur32, 0);
        chk({tag, "_cnt32"}, cnt32, 0);
        chk({tag, "_valid8"}, v8, 0);
        chk({tag, "_code8"}, code8, 0);
        chk({tag, "_dur8"}, dur8, 0);
        chk({tag, "_cnt8"}, cnt8, 0);
    endtask

    // Monitor: every color_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (v32) begin
            chk("sb_pending32", q32.size() > 0, 1);
            if (q32.size() > 0) begin
                e = q32.pop_front();
                $display("evt32 cyc=%0d code=%b dur=%0d cnt=%0d", cyc, code32, dur32, cnt32);
                chk("evt_cycle32", cyc, e.at);
                chk("evt_code32", code32, e.code);
                chk("evt_cnt32", cnt32, e.cnt);
                if (!e.dur_dc) chk("evt_dur32", dur32, e.dur);
            end
        end
        if (v8) begin
            chk("sb_pending8", q8.size() > 0, 1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                $display("evt8  cyc=%0d code=%b dur=%0d cnt=%0d", cyc, code8, dur8, cnt8);
                chk("evt_cycle8", cyc, e.at);
                chk("evt_code8", code8, e.code);
                chk("evt_cnt8", cnt8, e.cnt);
                if (!e.dur_dc) chk("evt_dur8", dur8, e.dur[7:0]);
            end
        end
    end

    initial begin
        int rr;
        wait_cyc(3);
        rst = 1'b0;
        chk_zero("reset");

        // All pins off for 50 cycles: silent.
        wait_cyc(50);
        chk("idle_code32", code32, 0);
        chk("idle_cnt32", cnt32, 0);

        // Red, green, blue, off at 100-cycle spacing.
        change(3'b100, 1); wait_cyc(100);
        change(3'b010, 1); wait_cyc(100);
        change(3'b001, 1); wait_cyc(100);
        change(3'b000, 1); wait_cyc(20);

        // 4-cycle red pulse rejected, 5-cycle pulse accepted.
        change(3'b100, 0); wait_cyc(4);
        change(3'b000, 0); wait_cyc(20);
        change(3'b100, 1); wait_cyc(5);
        change(3'b000, 1); wait_cyc(20);

        // Long green then white: 8-bit duration saturates.
        change(3'b010, 1); wait_cyc(400);
        change(3'b111, 1); wait_cyc(20);
        chk("hold_code32", code32, 3'b111);
        chk("hold_dur8", dur8, 8'd255);

        // Reset while a new color is mid-filter.
        change(3'b100, 0); wait_cyc(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rr = cyc;
        chk_zero("midreset");
        exp_cnt = 16'd0;
        last_c = rr;
        first_after_rst = 1'b1;
        push_evt(rr, 3'b100);
        wait_cyc(30);

        // Back-to-back changes at minimum spacing.
        change(3'b010, 1); wait_cyc(5);
        change(3'b011, 1); wait_cyc(5);
        change(3'b000, 1); wait_cyc(20);

        // Skewed pins: only the final combination is reported.
        change(3'b100, 0); wait_cyc(2);
        change(3'b110, 0); wait_cyc(2);
        change(3'b111, 1); wait_cyc(30);

        chk("sb_drained32", q32.size(), 0);
        chk("sb_drained8", q8.size(), 0);
        chk("final_cnt32", cnt32, exp_cnt);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_pin_decoder.md
# rgb_pin_decoder

Receive-side companion to the RGB LED driver path: samples the three active-low RGB pad signals, synchronizes and debounces them, decodes the settled level to a 3-bit color code, and measures how many clock cycles each color was held. Each accepted color change produces a one-cycle event carrying the new color and the dwell time of the color it replaced. It sits on loopback/monitor paths so the color sequencer can be checked in hardware or simulation from the pins alone.

## Interface
- STABLE_CYCLES, default 4, consecutive identical synchronized samples (beyond the first) required to accept a color; legal range ≥1
- DUR_WIDTH, default 32, width of dwell counter and duration output; legal range ≥2
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- rgb_r_n  input  1  red pad level, active-low (0 = LED on), asynchronous to clk
- rgb_g_n  input  1  green pad level, active-low
- rgb_b_n  input  1  blue pad level, active-low
- color_valid  output  1  one-cycle pulse: new color accepted
- color_code  output  3  accepted color {red,green,blue}, active-high; holds between events
- duration  output  DUR_WIDTH  cycles the previous color was held; updated with color_valid, holds between events
- event_count  output  16  number of accepted changes since reset, wraps 0xFFFF→0x0000

## Operation
- Synchronizer: two flops per pin, reset to 1 (LED off). Decoded sample s = bitwise inverse of second stage, ordered {r,g,b}.
- Filter: candidate register cand (reset 3'b000) and stability counter cnt (reset 0, width $clog2(STABLE_CYCLES)+1).
  - s != cand: cand <= s, cnt <= 0.
  - s == cand and cnt < STABLE_CYCLES: cnt <= cnt+1.
  - s == cand and cnt == STABLE_CYCLES: counter holds.
- Accept condition (evaluated each cycle): s == cand, cnt == STABLE_CYCLES-1 ... precisely: the edge at which cnt transitions to STABLE_CYCLES while cand != cur. Also accept if cnt already equals STABLE_CYCLES and cand != cur (cannot occur after reset; stated for completeness).
- Current color cur (reset 3'b000). On accept edge: cur <= cand, color_code <= cand, color_valid <= 1, duration <= dwell, dwell <= 1, event_count <= event_count+1. Otherwise color_valid <= 0, dwell <= dwell+1 saturating at all-ones.
- A settled sample equal to cur never generates an event (glitch that returns to the old color is silent).
- Any 3-bit combination, including 000 (all off) and 111 (white), is a valid color.
- Duration saturates at 2^DUR_WIDTH-1 and reports that value; dwell stays saturated until next accept.

## Timing
- Reset values: color_valid 0, color_code 000, duration 0, event_count 0, dwell 0, cur 000, cand 000, cnt 0, sync flops 1.
- Reset asserted mid-operation: all state returns to reset values on the next edge; no color_valid emitted during or in the cycle after reset; a pending candidate is discarded.
- Latency: pin change settles before rising edge 1 → sync stage 1 at edge 1, stage 2 at edge 2, cand loaded at edge 3, cnt reaches STABLE_CYCLES at edge STABLE_CYCLES+3 → color_valid high for exactly the cycle after edge STABLE_CYCLES+3 (edge 7 for default).
- Glitch rejection: decoded level lasting ≤STABLE_CYCLES cycles at s is never accepted; STABLE_CYCLES+1 cycles is accepted.
- Duration: with accept edges N cycles apart, duration = N. First event after reset reports cycles since reset deassertion (dwell starts at 0 on the first post-reset edge).
- Back-to-back changes: minimum spacing between color_valid pulses is STABLE_CYCLES+1 cycles.
- Pins changing at different edges (skew): each partial combination restarts the filter; only the final combination is reported if intermediates last ≤STABLE_CYCLES cycles.

## Test plan
- Reset then pins 3'b111 (all off) held 50 cycles → no color_valid, color_code 000, event_count 0.
- Drive rgb_r_n low after reset settles, STABLE_CYCLES=4 → color_valid one cycle after edge 7 from change, color_code 100, event_count 1.
- Cycle red→green→blue with changes exactly 100 cycles apart → second and third events report duration 100, color_codes 010 then 001.
- Red pulse of 4 cycles on otherwise-off pins → no event; 5-cycle pulse → one event color 100, then event back to 000 with duration 5.
- DUR_WIDTH=8, hold green 400 cycles then change to white → duration 255, color_code 111.
- Assert rst for 1 cycle while a new color is 2 cycles into filtering → all outputs 0 after reset edge, no event until color held STABLE_CYCLES+3 edges post-reset.
